// File: rtl/seq_divider_pkg.sv
// ---------------------------------------------------------------------------
// seq_divider_pkg
//   Shared arithmetic-unit definitions used by the sequential divider and its
//   combinational step cell.
//
//   Contents:
//     DEFAULT_WIDTH   : operand width shared with the multiply pipeline
//     state_t         : FSM state type of the sequential divider
//     ST_IDLE/RUN/DONE: FSM state encodings
//     is_ready()      : true in the states that may accept a new request
// ---------------------------------------------------------------------------
package seq_divider_pkg;

    // Operand width used across the arithmetic unit (multiply and divide).
    localparam int DEFAULT_WIDTH = 32;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // A new request may be taken while idle or in the single completion
    // cycle, which is what allows back-to-back operations without a bubble.
    function automatic logic is_ready(input state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage : seq_divider_pkg

// File: rtl/seq_divider_div_step.sv
// ---------------------------------------------------------------------------
// div_step
//   One restoring-division iteration, purely combinational. Usable on its own
//   as the cell of an unrolled or pipelined divider.
//
//   Parameters:
//     WIDTH    : operand width
//   Ports:
//     rem_in   in  WIDTH  partial remainder before this step (< divisor)
//     bit_in   in  1      next dividend bit, shifted into the remainder LSB
//     divisor  in  WIDTH  denominator
//     rem_out  out WIDTH  partial remainder after this step (< divisor)
//     q_bit    out 1      quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    // The trial value carries one extra bit: with rem_in < divisor the trial
    // is < 2*divisor, which can exceed WIDTH bits when the divisor MSB is set.
    logic [WIDTH:0] trial;
    logic [WIDTH:0] diff;

    always_comb begin
        trial = {rem_in, bit_in};
        diff  = trial - {1'b0, divisor};
        // The MSB of the WIDTH+1-bit difference is the borrow: clear means
        // trial >= divisor. When it is clear the difference is < divisor, so
        // it fits back into WIDTH bits.
        q_bit   = ~diff[WIDTH];
        rem_out = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    end

endmodule : div_step

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Multi-cycle unsigned restoring divider, one iteration per clock.
//   Computes quotient and remainder of a WIDTH-bit dividend by a WIDTH-bit
//   divisor in WIDTH cycles. Division by zero completes immediately with an
//   all-ones quotient, remainder = dividend and div_zero set.
//
//   Parameters:
//     WIDTH     : operand/result width (>= 2)
//     CNT_W     : iteration counter width (derived)
//   Ports:
//     clk       in  1      rising-edge clock
//     rst_n     in  1      asynchronous active-low reset
//     start     in  1      request, taken only while ready is high
//     dividend  in  WIDTH  numerator, captured when the request is taken
//     divisor   in  WIDTH  denominator, captured when the request is taken
//     ready     out 1      high in IDLE or DONE
//     busy      out 1      high while iterating
//     done      out 1      one-cycle completion pulse
//     quotient  out WIDTH  result, held until the next completion
//     remainder out WIDTH  result, held until the next completion
//     div_zero  out 1      divisor was zero; held with the results
//
//   Handshake: a request is transferred on a rising edge where start and
//   ready are both high. start while ready is low is ignored (not queued).
//   Operands only need to be stable at that edge. done rises in the cycle
//   after the final iteration (or right after the edge for a zero divisor)
//   and lasts exactly one cycle; quotient/remainder/div_zero are valid from
//   that cycle on and hold until the next operation completes.
// ---------------------------------------------------------------------------
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_zero
);

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t           state_q;
    state_t           state_d;

    logic [WIDTH-1:0] divisor_q;    // captured denominator
    logic [WIDTH-1:0] rem_q;        // partial remainder
    logic [WIDTH-1:0] sr_q;         // dividend bits out at the top, quotient bits in at the bottom
    logic [CNT_W-1:0] cnt_q;        // completed iterations
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_zero_q;

    logic             accept;
    logic             zero_req;
    logic             last_step;

    logic [WIDTH-1:0] step_rem;
    logic             step_q;
    logic [WIDTH-1:0] step_sr;

    assign accept    = start && is_ready(state_q);
    assign zero_req  = (divisor == '0);
    assign last_step = (state_q == ST_RUN) && (cnt_q == CNT_W'(WIDTH - 1));

    // ------------------------------------------------------------------
    // Single restoring iteration
    // ------------------------------------------------------------------
    div_step #(
        .WIDTH   (WIDTH)
    ) u_div_step (
        .rem_in  (rem_q),
        .bit_in  (sr_q[WIDTH-1]),
        .divisor (divisor_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    // The dividend MSB is consumed by this step; the new quotient bit
    // enters at the bottom, so after WIDTH steps sr holds the quotient.
    assign step_sr = {sr_q[WIDTH-2:0], step_q};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (accept) begin
                    state_d = zero_req ? ST_DONE : ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (last_step) begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        ready = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready = 1'b1;
            end
            ST_RUN: begin
                busy = 1'b1;
            end
            ST_DONE: begin
                ready = 1'b1;
                done  = 1'b1;
            end
            default: begin
                ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            divisor_q   <= '0;
            rem_q       <= '0;
            sr_q        <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else if (accept) begin
            divisor_q <= divisor;
            rem_q     <= '0;
            sr_q      <= dividend;
            cnt_q     <= '0;
            // A zero divisor completes on this edge; otherwise the previous
            // results stay visible until the new ones are ready.
            if (zero_req) begin
                quotient_q  <= '1;
                remainder_q <= dividend;
                div_zero_q  <= 1'b1;
            end
        end else if (state_q == ST_RUN) begin
            rem_q <= step_rem;
            sr_q  <= step_sr;
            cnt_q <= cnt_q + 1'b1;
            if (last_step) begin
                quotient_q  <= step_sr;
                remainder_q <= step_rem;
                div_zero_q  <= 1'b0;
            end
        end
    end

    assign quotient  = quotient_q;
    assign remainder = remainder_q;
    assign div_zero  = div_zero_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Directed and randomized checks of seq_divider with WIDTH=32.
//   Inputs change 1ns after a rising edge; outputs are sampled there too.
// ---------------------------------------------------------------------------
module tb_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_zero;

    int total;
    int bad;

    logic [W-1:0] exp_q[$];

    seq_divider #(
        .WIDTH     (W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div_zero  (div_zero)
    );

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // ------------------------------------------------------------------
    // Driver: present a request for one edge (E0), scramble the operands
    // afterwards, then wait for done. lat counts edges after E0; busy_cnt
    // counts sampled busy cycles before done.
    // ------------------------------------------------------------------
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cnt);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        tick();
        start    = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        lat      = 0;
        busy_cnt = 0;
        while (done !== 1'b1 && lat < 100) begin
            if (busy === 1'b1) busy_cnt++;
            tick();
            lat++;
        end
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        total++;
        if ({ready, busy, done, div_zero} !== 4'b1000) begin
            bad++;
            $display("FAIL reset_ctl: got rdy/busy/done/dz=%b required 1000",
                     {ready, busy, done, div_zero});
        end
        total++;
        if (quotient !== '0 || remainder !== '0) begin
            bad++;
            $display("FAIL reset_data: got q=%h r=%h required 0/0", quotient, remainder);
        end
    endtask

    task automatic test_basic();
        int lat;
        int bc;
        run_op(32'd100, 32'd7, lat, bc);
        total++;
        if (lat != 32) begin
            bad++;
            $display("FAIL basic_latency: got %0d required 32", lat);
        end
        total++;
        if (bc != 32) begin
            bad++;
            $display("FAIL basic_busy_cycles: got %0d required 32", bc);
        end
        total++;
        if (quotient !== 32'd14 || remainder !== 32'd2 || div_zero !== 1'b0) begin
            bad++;
            $display("FAIL basic_result: got q=%0d r=%0d dz=%b required 14/2/0",
                     quotient, remainder, div_zero);
        end
        total++;
        if (ready !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL basic_done_flags: got rdy=%b busy=%b required 1/0", ready, busy);
        end
        tick();
        total++;
        if (done !== 1'b0 || ready !== 1'b1 || quotient !== 32'd14 || remainder !== 32'd2) begin
            bad++;
            $display("FAIL basic_after_done: got done=%b rdy=%b q=%0d r=%0d required 0/1/14/2",
                     done, ready, quotient, remainder);
        end
    endtask

    task automatic test_extremes();
        logic [W-1:0] va[2];
        logic [W-1:0] vb[2];
        logic [W-1:0] eq;
        logic [W-1:0] er;
        int lat;
        int bc;
        va[0] = 32'hFFFF_FFFF; vb[0] = 32'h0000_0001;
        va[1] = 32'hFFFF_FFFF; vb[1] = 32'h8000_0000;
        exp_q.push_back(32'hFFFF_FFFF); exp_q.push_back(32'h0000_0000);
        exp_q.push_back(32'h0000_0001); exp_q.push_back(32'h7FFF_FFFF);
        for (int i = 0; i < 2; i++) begin
            run_op(va[i], vb[i], lat, bc);
            eq = exp_q.pop_front();
            er = exp_q.pop_front();
            total++;
            if (lat != 32 || quotient !== eq || remainder !== er || div_zero !== 1'b0) begin
                bad++;
                $display("FAIL extreme_%0d: got lat=%0d q=%h r=%h dz=%b required 32/%h/%h/0",
                         i, lat, quotient, remainder, div_zero, eq, er);
            end
        end
    endtask

    task automatic test_small_and_zero();
        int lat;
        int bc;
        run_op(32'd3, 32'd10, lat, bc);
        total++;
        if (lat != 32 || quotient !== 32'd0 || remainder !== 32'd3) begin
            bad++;
            $display("FAIL small_dividend: got lat=%0d q=%0d r=%0d required 32/0/3",
                     lat, quotient, remainder);
        end
        run_op(32'd5, 32'd0, lat, bc);
        total++;
        if (lat != 0 || bc != 0) begin
            bad++;
            $display("FAIL zero_latency: got lat=%0d busy=%0d required 0/0", lat, bc);
        end
        total++;
        if (quotient !== 32'hFFFF_FFFF || remainder !== 32'd5 || div_zero !== 1'b1) begin
            bad++;
            $display("FAIL zero_result: got q=%h r=%0d dz=%b required ffffffff/5/1",
                     quotient, remainder, div_zero);
        end
        tick();
        total++;
        if (done !== 1'b0 || div_zero !== 1'b1 || remainder !== 32'd5) begin
            bad++;
            $display("FAIL zero_hold: got done=%b dz=%b r=%0d required 0/1/5",
                     done, div_zero, remainder);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        start    = 1'b1;
        dividend = 32'd1000;
        divisor  = 32'd3;
        tick();
        start = 1'b0;
        cyc   = 0;
        repeat (4) begin
            tick();
            cyc++;
        end
        // Request while busy: must be ignored.
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd9;
        tick();
        cyc++;
        start = 1'b0;
        total++;
        if (busy !== 1'b1 || ready !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_flags: got busy=%b rdy=%b required 1/0", busy, ready);
        end
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        total++;
        if (cyc != 32 || quotient !== 32'd333 || remainder !== 32'd1) begin
            bad++;
            $display("FAIL busy_ignore_result: got lat=%0d q=%0d r=%0d required 32/333/1",
                     cyc, quotient, remainder);
        end
        // Accept in the DONE cycle, no bubble.
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd9;
        tick();
        start = 1'b0;
        cyc   = 0;
        total++;
        if (busy !== 1'b1 || done !== 1'b0 || quotient !== 32'd333) begin
            bad++;
            $display("FAIL b2b_accept: got busy=%b done=%b q=%0d required 1/0/333",
                     busy, done, quotient);
        end
        while (done !== 1'b1 && cyc < 100) begin
            tick();
            cyc++;
        end
        total++;
        if (cyc != 32 || quotient !== 32'd1 || remainder !== 32'd0) begin
            bad++;
            $display("FAIL b2b_result: got lat=%0d q=%0d r=%0d required 32/1/0",
                     cyc, quotient, remainder);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int pulses;
        start    = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst_n = 1'b0;
        #1;
        total++;
        if ({ready, busy, done, div_zero} !== 4'b1000 || quotient !== '0 || remainder !== '0) begin
            bad++;
            $display("FAIL midreset_async: got rdy/busy/done/dz=%b q=%h r=%h required 1000/0/0",
                     {ready, busy, done, div_zero}, quotient, remainder);
        end
        tick();
        rst_n  = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (done !== 1'b0) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL midreset_stale_done: got %0d pulses required 0", pulses);
        end
        total++;
        if ({ready, busy, div_zero} !== 3'b100 || quotient !== '0 || remainder !== '0) begin
            bad++;
            $display("FAIL midreset_idle: got rdy/busy/dz=%b q=%h r=%h required 100/0/0",
                     {ready, busy, div_zero}, quotient, remainder);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] eq;
        logic [W-1:0] er;
        longint unsigned recon;
        int lat;
        int bc;
        int errs;
        errs = 0;
        for (int i = 0; i < 250; i++) begin
            a = $urandom;
            if (i % 3 == 0) b = $urandom_range(1, 255);
            else            b = $urandom >> $urandom_range(0, 31);
            if (b == '0) b = 32'd1;
            exp_q.push_back(a / b);
            exp_q.push_back(a % b);
            run_op(a, b, lat, bc);
            eq    = exp_q.pop_front();
            er    = exp_q.pop_front();
            recon = longint'(quotient) * longint'(b) + longint'(remainder);
            total++;
            if (lat != 32 || quotient !== eq || remainder !== er ||
                recon != longint'(a) || !(remainder < b) || div_zero !== 1'b0) begin
                bad++;
                errs++;
                if (errs <= 10)
                    $display("FAIL random_%0d: %h/%h got lat=%0d q=%h r=%h required 32/%h/%h",
                             i, a, b, lat, quotient, remainder, eq, er);
            end
        end
        tick();
    endtask

    // ------------------------------------------------------------------
    // Sequence and report
    // ------------------------------------------------------------------
    initial begin
        total = 0;
        bad   = 0;
        do_reset();
        test_reset();
        test_basic();
        test_extremes();
        test_small_and_zero();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_seq_divider
